// File: rtl/ir_prefetch_queue.sv
// Instruction prefetch FIFO between program-memory fetch and the control unit.
// Head word is combinational from registered state; flush discards all entries on a taken jump.
module ir_prefetch_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wIR,
   input  logic [WIDTH-1:0] nIR,
   input  logic             aIR,
   input  logic             flush,
   output logic [WIDTH-1:0] rIR,
   output logic             valid,
   output logic             full,
   output logic [CW-1:0]    count,
   output logic             ovf,
   output logic             udf
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             r_ovf;
   logic             r_udf;

   logic w_empty;
   logic w_full;
   logic w_pop_acc;
   logic w_push_acc;

   // Count, not pointer equality, separates full from empty once the pointers wrap.
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CW'(DEPTH));
   assign w_pop_acc  = aIR && !w_empty;
   assign w_push_acc = wIR && (!w_full || w_pop_acc);

   assign rIR   = w_empty ? '0 : r_mem[r_rd_ptr];
   assign valid = !w_empty;
   assign full  = w_full;
   assign count = r_count;
   assign ovf   = r_ovf;
   assign udf   = r_udf;

   // NOTE: storage has no reset; an empty queue masks its head to zero, so stale
   // contents are never observable and the array stays a plain register file.
   always_ff @(posedge clk) begin
      if (!flush && w_push_acc) begin
         r_mem[r_wr_ptr] <= nIR;
      end
   end

   // NOTE: all state uses non-blocking assignments so every term on the right
   // reads the pre-edge value, which is what the push/pop rules are defined against.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else if (flush) begin
         r_rd_ptr <= r_wr_ptr;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_push_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop_acc) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push_acc) - CW'(w_pop_acc);
         if (wIR && w_full && !w_pop_acc) begin
            r_ovf <= 1'b1;
         end
         if (aIR && w_empty) begin
            r_udf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Directed self-checking bench for ir_prefetch_queue (WIDTH=8, DEPTH=4).
module tb_ir_prefetch_queue;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             wIR;
   logic [WIDTH-1:0] nIR;
   logic             aIR;
   logic             flush;
   logic [WIDTH-1:0] rIR;
   logic             valid;
   logic             full;
   logic [CW-1:0]    count;
   logic             ovf;
   logic             udf;

   int n_checks = 0;
   int n_errors = 0;

   ir_prefetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .wIR   (wIR),
      .nIR   (nIR),
      .aIR   (aIR),
      .flush (flush),
      .rIR   (rIR),
      .valid (valid),
      .full  (full),
      .count (count),
      .ovf   (ovf),
      .udf   (udf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of strobes, clock, then return to idle 1 time unit after the edge.
   task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic a, input logic f);
      wIR   = w;
      nIR   = d;
      aIR   = a;
      flush = f;
      @(posedge clk);
      #1;
      wIR   = 1'b0;
      aIR   = 1'b0;
      flush = 1'b0;
   endtask

   task automatic check_state(input string tag, input logic [WIDTH-1:0] e_rir,
                              input int e_cnt, input logic e_ovf, input logic e_udf);
      check({tag, ".rIR"},   32'(rIR),   32'(e_rir));
      check({tag, ".count"}, 32'(count), 32'(e_cnt));
      check({tag, ".valid"}, 32'(valid), 32'(e_cnt != 0));
      check({tag, ".full"},  32'(full),  32'(e_cnt == DEPTH));
      check({tag, ".ovf"},   32'(ovf),   32'(e_ovf));
      check({tag, ".udf"},   32'(udf),   32'(e_udf));
   endtask

   initial begin
      logic [WIDTH-1:0] seq [11];
      logic [WIDTH-1:0] fill [4];
      logic [WIDTH-1:0] drain2 [4];
      fill   = '{8'h00, 8'h10, 8'h20, 8'h30};
      drain2 = '{8'h10, 8'h20, 8'h30, 8'h50};
      for (int i = 0; i < 11; i++) seq[i] = 8'(8'h81 + 8'(i * 7));

      rst = 1'b1; wIR = 1'b0; nIR = '0; aIR = 1'b0; flush = 1'b0;
      #12 rst = 1'b0;
      #1;
      check_state("reset", 8'h00, 0, 1'b0, 1'b0);

      // Set udf and hold two words, then reset mid-cycle.
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_state("udf_pre", 8'h00, 0, 1'b0, 1'b1);
      step(1'b1, 8'hA1, 1'b0, 1'b0);
      step(1'b1, 8'hA2, 1'b0, 1'b0);
      check_state("two_words", 8'hA1, 2, 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1;
      check_state("mid_reset", 8'h00, 0, 1'b0, 1'b0);
      #2 rst = 1'b0;

      // Fill and drain.
      for (int i = 0; i < 4; i++) step(1'b1, fill[i], 1'b0, 1'b0);
      check_state("filled", 8'h00, 4, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("drain.rIR", 32'(rIR), 32'(fill[i]));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      check_state("drained", 8'h00, 0, 1'b0, 1'b0);

      // Overflow, then push+pop while full.
      for (int i = 0; i < 4; i++) step(1'b1, fill[i], 1'b0, 1'b0);
      step(1'b1, 8'h40, 1'b0, 1'b0);
      check_state("ovf", 8'h00, 4, 1'b1, 1'b0);
      step(1'b1, 8'h50, 1'b1, 1'b0);
      check_state("full_pushpop", 8'h10, 4, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("drain2.rIR", 32'(rIR), 32'(drain2[i]));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      check_state("drained2", 8'h00, 0, 1'b1, 1'b0);

      // Hold without strobe.
      step(1'b1, 8'h10, 1'b0, 1'b0);
      step(1'b0, 8'h20, 1'b0, 1'b0);
      check_state("hold", 8'h10, 1, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Underflow, then push+pop on empty.
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_state("udf", 8'h00, 0, 1'b1, 1'b1);
      step(1'b1, 8'h33, 1'b1, 1'b0);
      check_state("empty_pushpop", 8'h33, 1, 1'b1, 1'b1);

      // Flush beats simultaneous push and pop.
      step(1'b1, 8'h61, 1'b0, 1'b0);
      step(1'b1, 8'h62, 1'b0, 1'b0);
      step(1'b1, 8'h63, 1'b0, 1'b0);
      check_state("pre_flush", 8'h33, 4, 1'b1, 1'b1);
      step(1'b1, 8'h77, 1'b1, 1'b1);
      check_state("flush", 8'h00, 0, 1'b0, 1'b0);

      // Streaming push/pop pairs wrap both pointers several times.
      step(1'b1, seq[0], 1'b0, 1'b0);
      check_state("wrap_start", seq[0], 1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check("wrap.rIR", 32'(rIR), 32'(seq[i]));
         step(1'b1, seq[i+1], 1'b1, 1'b0);
         check("wrap.count", 32'(count), 32'd1);
      end
      check("wrap_last.rIR", 32'(rIR), 32'(seq[10]));
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_state("wrap_end", 8'h00, 0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
- Parametrised successor to the single-register instruction register: a DEPTH-entry, WIDTH-bit instruction prefetch FIFO between program-memory fetch and the control unit.
- Fetch pushes instruction words ahead of execution; the control unit consumes the head word.
- On a taken jump the control unit flushes the queue.
- Adds occupancy reporting and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 8, bits per instruction word.
- DEPTH, 4, number of entries; power of two, ≥2.
- CW, $clog2(DEPTH+1), width of the count output (derived, not overridden).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- wIR  input  1  push strobe: write nIR into tail.
- nIR  input  WIDTH  word to push.
- aIR  input  1  advance strobe: pop head.
- flush  input  1  discard all entries (taken jump).
- rIR  output  WIDTH  head word; all-zeros when empty.
- valid  output  1  queue non-empty (count != 0).
- full  output  1  count == DEPTH.
- count  output  CW  current occupancy, 0..DEPTH.
- ovf  output  1  sticky: push attempted while full with no simultaneous pop.
- udf  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, any time, including mid-operation): rd_ptr = wr_ptr = 0, count = 0, ovf = udf = 0. Hence rIR = 0, valid = 0, full = 0. Storage contents need not be cleared.
- Storage: DEPTH×WIDTH register array; rd_ptr/wr_ptr are log2(DEPTH)-bit and wrap modulo DEPTH naturally.
- Outputs rIR, valid, full, count are combinational from registered state; no extra output latency.
- Push latency: a word pushed at edge N is visible on rIR after edge N if the queue was empty. Push-to-head latency is 1 cycle; no bypass within the same cycle.
- Pop: on the posedge with aIR=1 and valid=1, rd_ptr advances and the next entry (or 0 if now empty) appears on rIR.
- Priority per posedge, in order:
  1. flush=1: rd_ptr ← wr_ptr, count ← 0, ovf ← 0, udf ← 0. wIR and aIR are ignored that cycle; the pushed word is dropped.
  2. Otherwise, evaluate push and pop independently against the pre-edge state:
     - Pop accepted iff aIR && count != 0.
     - Push accepted iff wIR && (count != DEPTH || pop accepted).
     - Full with simultaneous push+pop: both accepted, count unchanged, pointers both advance.
     - Empty with simultaneous push+pop: pop rejected (udf ← 1), push accepted, count becomes 1.
     - count ← count + push_acc − pop_acc.
  3. ovf ← 1 when wIR && full && !pop_acc. udf ← 1 when aIR && count == 0. Both stay set until flush or rst.
- Rejected operations never modify storage, pointers, or count.
- Pointer wrap: after DEPTH pushes without pops, wr_ptr == rd_ptr with count == DEPTH. count, not pointer equality, disambiguates full from empty.
- nIR is sampled only when the push is accepted; X on nIR while wIR=0 is harmless.
- Flush does not touch rIR storage. The head is invalidated by count = 0, so rIR reads 0.
- Outputs never go X after the first reset.

Test Plan:
- Reset then idle: assert rst mid-cycle with the queue holding 2 words → immediately rIR=0, valid=0, count=0, full=0, ovf=udf=0.
- Fill/drain (WIDTH=8, DEPTH=4): push 0x00, 0x10, 0x20, 0x30 → full=1, count=4. Pop four times → rIR sequence 0x00, 0x10, 0x20, 0x30, then valid=0, rIR=0.
- Overflow and full push+pop:
  - When full, push 0x40 alone → dropped, ovf=1, count=4.
  - Then push 0x50 with aIR=1 → count stays 4; drain yields 0x10, 0x20, 0x30, 0x50.
- Hold-without-strobe: with 0x10 at head, present nIR=0x20, wIR=0, clock → rIR stays 0x10, count unchanged.
- Underflow and empty push+pop:
  - Pop on empty → udf=1, count=0.
  - Then push 0x33 with aIR=1 on empty → count=1, rIR=0x33, udf=1.
- Flush priority and wrap:
  - Push 3 words, then flush with wIR=1 (nIR=0x77) and aIR=1 → count=0, ovf=udf=0, 0x77 not stored.
  - Then run 10 push/pop pairs with distinct data → pointers wrap and every word is popped in order.
